// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator command sequencer.
// Holds the keypad command codes, ALU operator codes, display status codes,
// sequencer states, and the operand width/digit limits.
package calc_pkg;
    localparam int NDIG = 8;
    localparam int W    = 27;
    localparam int CW   = 4;
    localparam logic [W-1:0] MAX_VAL = W'(10 ** NDIG - 1);

    typedef enum logic [3:0] {
        C_D0, C_D1, C_D2, C_D3, C_D4, C_D5, C_D6, C_D7, C_D8, C_D9,
        C_ADD, C_SUB, C_MUL, C_BSP, C_EQ, C_CLR
    } cmd_e;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} alu_op_e;

    typedef enum logic [1:0] {ST_ENTRY_A, ST_ENTRY_B, ST_BUSY, ST_ERROR} status_e;

    typedef enum logic [2:0] {S_A, S_OP, S_B, S_START, S_WAIT, S_RES, S_ERR} state_e;
endpackage

// File: rtl/calc_seq_if.sv
// calc_seq_if: bus bundles around the sequencer.
// calc_cmd_if: keypad command channel (cmd/cmd_valid/cmd_ready) plus the
//   display outputs (digits/status); master = keypad/top, slave = sequencer.
// calc_alu_if: ALU start/done handshake with operands and result;
//   master = sequencer, slave = ALU.
interface calc_cmd_if;
    import calc_pkg::*;
    cmd_e          cmd;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  digits;
    status_e       status;
    modport master (output cmd, cmd_valid, input cmd_ready, digits, status);
    modport slave  (input cmd, cmd_valid, output cmd_ready, digits, status);
endinterface

interface calc_alu_if;
    import calc_pkg::*;
    logic          alu_start;
    alu_op_e       alu_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_done;
    logic [W-1:0]  alu_result;
    logic          alu_ovf;
    modport master (output alu_start, alu_op, alu_a, alu_b, input alu_done, alu_result, alu_ovf);
    modport slave  (input alu_start, alu_op, alu_a, alu_b, output alu_done, alu_result, alu_ovf);
endinterface

// File: rtl/calc_dec_edit.sv
// calc_dec_edit: combinational decimal operand editor.
// Ports: val_i/cnt_i current operand and digit count, cmd_i keypad command;
//   next_val_o/next_cnt_o edited operand and count. Digits append (val*10+d)
//   unless NDIG digits are held, BACKSPACE drops the last digit (val/10);
//   any other command passes the operand through unchanged.
module calc_dec_edit
    import calc_pkg::*;
(
    input  logic [W-1:0]  val_i,
    input  logic [CW-1:0] cnt_i,
    input  cmd_e          cmd_i,
    output logic [W-1:0]  next_val_o,
    output logic [CW-1:0] next_cnt_o
);
    localparam int MW = W + 4;
    logic [MW-1:0] mac;
    logic          app, del;
    always_comb begin
        mac = MW'(val_i) * MW'(10) + MW'(cmd_i);
        app = cmd_i <= C_D9 && cnt_i < CW'(NDIG);
        del = cmd_i == C_BSP && cnt_i != '0;
        next_val_o = app ? mac[W-1:0] : del ? val_i / W'(10) : val_i;
        // a zero typed into an empty operand is a leading zero and is not counted
        next_cnt_o = app && mac != '0 ? cnt_i + 1'b1 : del ? cnt_i - 1'b1 : cnt_i;
    end
endmodule

// File: rtl/calc_seq.sv
// calc_seq: calculator command sequencer.
// Ports: clk_i clock, rst_ni async active-low reset, cmd_if keypad command
//   channel and display outputs (slave), alu_if start/done handshake to the
//   shared multi-cycle ALU (master). Builds A, op and B from keypad commands,
//   launches the ALU, and presents the operand or result with a status code.
//   All outputs are registered.
module calc_seq
    import calc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    calc_cmd_if.slave  cmd_if,
    calc_alu_if.master alu_if
);
    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d, digits_q, digits_d;
    logic [CW-1:0] ca_q, ca_d, cb_q, cb_d;
    alu_op_e       op_q, op_d, alu_op_q, alu_op_d, new_op;
    status_e       status_q, status_d;
    logic          chain_q, chain_d, ready_q, ready_d, start_q, start_d;
    logic          acc, dig, isop, edit, go, busy_d;
    logic [W-1:0]  ed_val, ed_nval;
    logic [CW-1:0] ed_cnt, ed_ncnt;

    calc_dec_edit u_edit (
        .val_i      (ed_val),
        .cnt_i      (ed_cnt),
        .cmd_i      (cmd_if.cmd),
        .next_val_o (ed_nval),
        .next_cnt_o (ed_ncnt)
    );

    always_comb begin
        acc    = cmd_if.cmd_valid && ready_q;
        dig    = cmd_if.cmd <= C_D9;
        isop   = cmd_if.cmd inside {C_ADD, C_SUB, C_MUL};
        edit   = dig || cmd_if.cmd == C_BSP;
        new_op = cmd_if.cmd == C_ADD ? OP_ADD : cmd_if.cmd == C_SUB ? OP_SUB : OP_MUL;
        // S_OP and S_RES start a fresh operand, so the editor sees an empty one
        ed_val = state_q == S_B ? b_q : state_q == S_A ? a_q : '0;
        ed_cnt = state_q == S_B ? cb_q : state_q == S_A ? ca_q : '0;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ca_d     = ca_q;
        cb_d     = cb_q;
        op_d     = op_q;
        chain_d  = chain_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        go       = 1'b0;
        case (state_q)
            S_A: if (acc) begin
                if (edit) begin
                    a_d  = ed_nval;
                    ca_d = ed_ncnt;
                end
                if (isop) begin
                    op_d    = new_op;
                    state_d = S_OP;
                end
            end
            S_OP: if (acc) begin
                if (isop) op_d = new_op;
                if (dig) begin
                    b_d     = ed_nval;
                    cb_d    = ed_ncnt;
                    state_d = S_B;
                end
                if (cmd_if.cmd == C_EQ) begin
                    b_d = a_q;
                    go  = 1'b1;
                end
            end
            S_B: if (acc) begin
                if (edit) begin
                    b_d  = ed_nval;
                    cb_d = ed_ncnt;
                end
                // an operator here runs the pending op and queues the new one
                if (isop) begin
                    op_d    = new_op;
                    chain_d = 1'b1;
                end
                go = isop || cmd_if.cmd == C_EQ;
            end
            S_START: state_d = S_WAIT;
            S_WAIT: if (alu_if.alu_done) begin
                chain_d = 1'b0;
                if (alu_if.alu_ovf || alu_if.alu_result > MAX_VAL) state_d = S_ERR;
                else begin
                    a_d     = alu_if.alu_result;
                    ca_d    = '0;
                    state_d = chain_q ? S_OP : S_RES;
                end
            end
            S_RES: if (acc) begin
                if (dig) begin
                    a_d     = ed_nval;
                    ca_d    = ed_ncnt;
                    state_d = S_A;
                end
                if (isop) begin
                    op_d    = new_op;
                    state_d = S_OP;
                end
                go = cmd_if.cmd == C_EQ;
            end
            default: ;
        endcase
        // the ALU always runs the op latched before this command
        if (go) begin
            state_d  = S_START;
            alu_a_d  = a_q;
            alu_b_d  = b_d;
            alu_op_d = op_q;
        end
        if (acc && cmd_if.cmd == C_CLR) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            ca_d    = '0;
            cb_d    = '0;
            chain_d = 1'b0;
        end
        busy_d   = state_d inside {S_START, S_WAIT};
        digits_d = state_d == S_ERR ? '0 : busy_d ? digits_q : state_d == S_B ? b_d : a_d;
        status_d = state_d == S_ERR ? ST_ERROR : busy_d ? ST_BUSY :
                   state_d inside {S_OP, S_B} ? ST_ENTRY_B : ST_ENTRY_A;
        ready_d  = !busy_d;
        start_d  = state_d == S_START;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            ca_q     <= '0;
            cb_q     <= '0;
            op_q     <= OP_ADD;
            chain_q  <= 1'b0;
            alu_op_q <= OP_ADD;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            digits_q <= '0;
            status_q <= ST_ENTRY_A;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ca_q     <= ca_d;
            cb_q     <= cb_d;
            op_q     <= op_d;
            chain_q  <= chain_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            digits_q <= digits_d;
            status_q <= status_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
        end
    end

    assign cmd_if.cmd_ready = ready_q;
    assign cmd_if.digits    = digits_q;
    assign cmd_if.status    = status_q;
    assign alu_if.alu_start = start_q;
    assign alu_if.alu_op    = alu_op_q;
    assign alu_if.alu_a     = alu_a_q;
    assign alu_if.alu_b     = alu_b_q;
endmodule

// File: doc/calc_seq.md
# calc_seq

Command sequencer for the calculator. Accepts keypad commands, builds operand A, the operator and operand B in registers, and runs the shared multi-cycle ALU through a start/done handshake. It presents the value to be shown and a 2-bit status to the display/top level. It sits between the keypad command input and `calc_alu`, and replaces ad-hoc digit accumulation in the top level.

## Interface
- `NDIG`, 8: maximum decimal digits per operand and result.
- `W`, 27: operand/result width in bits. It must satisfy 2^W > 10^NDIG − 1.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd`  in  4  command code: 0–9 digit, 10 ADD, 11 SUB, 12 MUL, 13 BACKSPACE, 14 EQUALS, 15 CLEAR.
- `cmd_valid`  in  1  `cmd` is valid this cycle.
- `cmd_ready`  out  1  command is accepted when `cmd_valid && cmd_ready`.
- `digits`  out  W  value to display: the operand being entered, or the result.
- `status`  out  2  00 ENTRY_A, 01 ENTRY_B, 10 BUSY, 11 ERROR.
- `alu_start`  out  1  single-cycle start pulse.
- `alu_op`  out  2  00 ADD, 01 SUB, 10 MUL; held stable from start until done.
- `alu_a`, `alu_b`  out  W  operands; held stable from start until done.
- `alu_done`  in  1  single-cycle pulse; `alu_result`/`alu_ovf` are valid in the same cycle.
- `alu_result`  in  W  ALU result.
- `alu_ovf`  in  1  ALU overflow or negative result.

## Operation
- States: S_A, S_OP, S_B, S_START, S_WAIT, S_RES, S_ERR.
- Digit entry, both operands: `val <= val*10 + d`.
  - A digit is ignored if the operand already holds NDIG digits. A digit counter is kept per operand.
  - Leading zeros do not count toward NDIG.
- BACKSPACE: `val <= val/10` and the digit count is decremented. It is a no-op at count 0.
- S_A:
  - Digits and BACKSPACE edit A.
  - An operator latches `op` and moves to S_OP. This is allowed with A = 0.
  - EQUALS is a no-op.
- S_OP:
  - Another operator replaces `op`.
  - A digit starts B (count 0, B = d) and moves to S_B.
  - EQUALS uses B = A and goes to S_START.
  - BACKSPACE is a no-op.
- S_B:
  - Digits and BACKSPACE edit B.
  - EQUALS goes to S_START.
  - An operator chains: A, B and `op` go to the ALU as for EQUALS, and the new operator is latched as pending `op`. After done, the FSM goes to S_OP with A = result.
- S_START: assert `alu_start` for one cycle, then go to S_WAIT.
- S_WAIT:
  - On `alu_done`: if `alu_ovf` is set or the result exceeds 10^NDIG − 1, go to S_ERR.
  - Otherwise A <= result and go to S_RES, or to S_OP for a chained operator.
- S_RES:
  - A digit starts a new A (= d) and goes to S_A.
  - An operator uses the result as A and goes to S_OP.
  - EQUALS repeats the last `op` with the last B.
  - BACKSPACE is a no-op.
- S_ERR: all commands except CLEAR are ignored.
- CLEAR in any state except S_START/S_WAIT: A = B = 0, counts = 0, go to S_A.
- `cmd_ready` = 0 in S_START and S_WAIT, 1 otherwise. Commands offered while not ready are not consumed.
- `digits`:
  - A in S_A, S_OP and S_RES.
  - B in S_B.
  - Frozen at the last value in S_START and S_WAIT.
  - 0 in S_ERR.
- `status`:
  - ENTRY_A in S_A and S_RES.
  - ENTRY_B in S_OP and S_B.
  - BUSY in S_START and S_WAIT.
  - ERROR in S_ERR.

## Timing
- Reset values:
  - State S_A; A, B, counts and `op` all 0.
  - `digits` = 0, `status` = 00, `cmd_ready` = 1.
  - `alu_start` = 0, `alu_op` = 00, `alu_a` = `alu_b` = 0.
- All outputs are registered.
- An accepted command is visible on `digits`/`status` on the next rising edge (1-cycle latency).
- EQUALS accepted at edge N:
  - `alu_start` is high in cycle N+1.
  - `cmd_ready` is low from cycle N+1 until the cycle after `alu_done`.
- `alu_done` at edge M: the result is on `digits` and `cmd_ready` = 1 at edge M+1.
- `alu_done` must not be sampled in the `alu_start` cycle. The ALU latency is at least 1 cycle.
- Reset is asserted asynchronously mid-operation. `alu_start` drops immediately. The ALU is reset by the same net.
- A stray `alu_done` outside S_WAIT is ignored.

## Structure
- Package `calc_pkg` holds:
  - `cmd_e` (16 codes), `alu_op_e`, `status_e`, the `state_e` enum;
  - constants NDIG, W and `MAX_VAL` = 10^NDIG − 1.
- The `val*10 + d` and `val/10` logic lives in a sub-module `calc_dec_edit`: combinational, with inputs `val`, `cnt`, `cmd` and outputs `next_val`, `next_cnt`. It is instantiated once and muxed between A and B.
- `calc_alu` is external. The bench uses a behavioural model with programmable latency.

## Test plan
- Reset, then digits 1,2,3 → `digits` = 1, 12, 123; `status` = 00 throughout.
- 9 digits of 9 → `digits` stays at 99999999 after the 8th digit; BACKSPACE → 9999999.
- 12, ADD, 30, EQUALS with ALU latency 5 → `status` = 10 and `cmd_ready` = 0 for exactly 6 cycles; then `digits` = 42, `status` = 00. A second EQUALS → 72.
- 5, SUB, 7, EQUALS with the model asserting `alu_ovf` → `status` = 11, `digits` = 0. Digits are ignored; CLEAR → `status` = 00, `digits` = 0.
- 2, MUL, 3, ADD, 4, EQUALS → the intermediate `digits` = 6 with `status` = 01, final `digits` = 10.
- Assert reset mid S_WAIT → outputs return to reset values asynchronously, and a late `alu_done` after release has no effect.
